// File: rtl/run_detector.sv
`default_nettype none
// ============================================================================
//  Module   : run_detector
//  Purpose  : Per-channel run-length detector. Raises a level while a channel
//             has seen at least MIN_RUN consecutive matching samples, pulses
//             hit on entry to detection and counts detections per channel.
//  Revision : 1.0  initial release
// ============================================================================
module run_detector #(
    parameter int CH      = 4,
    parameter int MIN_RUN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pol,
    input  logic                  clr,
    input  logic [CH-1:0]         data_in,
    output logic [CH-1:0]         out,
    output logic [CH-1:0]         hit,
    output logic [CH*CNT_W-1:0]   evt_cnt
);

    localparam int                 c_RUN_W   = $clog2(MIN_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_MIN_RUN = c_RUN_W'(MIN_RUN);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DETECT = 2'd2
    } state_t;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_RUN_W-1:0] r_run_cnt;
        logic [c_RUN_W-1:0] w_run_nxt;
        logic               w_match;
        logic               w_hit_nxt;
        logic               r_hit;
        logic [CNT_W-1:0]   r_evt;

        assign w_match = data_in[c] ^ pol;

        always_comb begin
            w_state_nxt = r_state;
            w_run_nxt   = r_run_cnt;
            w_hit_nxt   = 1'b0;
            if (en) begin
                case (r_state)
                    IDLE: begin
                        if (w_match) begin
                            if (MIN_RUN == 1) begin
                                w_state_nxt = DETECT;
                                w_run_nxt   = c_MIN_RUN;
                                w_hit_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = COUNT;
                                w_run_nxt   = c_RUN_ONE;
                            end
                        end
                    end
                    COUNT: begin
                        if (w_match) begin
                            w_run_nxt = r_run_cnt + c_RUN_ONE;
                            if (w_run_nxt == c_MIN_RUN) begin
                                w_state_nxt = DETECT;
                                w_hit_nxt   = 1'b1;
                            end
                        end else begin
                            w_state_nxt = IDLE;
                            w_run_nxt   = '0;
                        end
                    end
                    DETECT: begin
                        if (w_match) begin
                            w_run_nxt = c_MIN_RUN;
                        end else begin
                            w_state_nxt = IDLE;
                            w_run_nxt   = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_run_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state   <= IDLE;
                r_run_cnt <= '0;
                r_hit     <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_run_cnt <= w_run_nxt;
                r_hit     <= w_hit_nxt;
            end
        end

        // Clear takes priority over a same-edge increment; count saturates.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_evt <= '0;
            end else if (clr) begin
                r_evt <= '0;
            end else if (w_hit_nxt && (r_evt != c_CNT_MAX)) begin
                r_evt <= r_evt + c_CNT_ONE;
            end
        end

        assign out[c]                     = (r_state == DETECT);
        assign hit[c]                     = r_hit;
        assign evt_cnt[c*CNT_W +: CNT_W]  = r_evt;
    end

endmodule
`default_nettype wire

// File: tb/tb_run_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_detector
//  Purpose  : Scoreboard bench for run_detector with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_run_detector;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] h;
        logic [7:0] c;
    } exp_a_t;

    typedef struct packed {
        logic [1:0]  o;
        logic [1:0]  h;
        logic [15:0] c;
    } exp_b_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       a_en = 1'b0, a_pol = 1'b0, a_clr = 1'b0;
    logic [3:0] a_data = '0;
    logic [3:0] a_out, a_hit;
    logic [7:0] a_cnt;

    logic        b_en = 1'b0, b_pol = 1'b0, b_clr = 1'b0;
    logic [1:0]  b_data = '0;
    logic [1:0]  b_out, b_hit;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    exp_a_t qa[$];
    exp_b_t qb[$];

    always #5 clk = ~clk;

    run_detector #(.CH(4), .MIN_RUN(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .pol(a_pol), .clr(a_clr),
        .data_in(a_data), .out(a_out), .hit(a_hit), .evt_cnt(a_cnt)
    );

    run_detector #(.CH(2), .MIN_RUN(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .pol(b_pol), .clr(b_clr),
        .data_in(b_data), .out(b_out), .hit(b_hit), .evt_cnt(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_a(input logic e, input logic p, input logic c, input logic [3:0] d,
                          input logic [3:0] eo, input logic [3:0] eh, input logic [7:0] ec);
        exp_a_t x;
        @(negedge clk);
        a_en = e; a_pol = p; a_clr = c; a_data = d;
        x.o = eo; x.h = eh; x.c = ec;
        qa.push_back(x);
    endtask

    task automatic step_b(input logic [1:0] d, input logic [1:0] eo,
                          input logic [1:0] eh, input logic [15:0] ec);
        exp_b_t x;
        @(negedge clk);
        b_en = 1'b1; b_data = d;
        x.o = eo; x.h = eh; x.c = ec;
        qb.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        exp_a_t ea;
        exp_b_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_out", 32'(a_out), 32'(ea.o));
                chk("a_hit", 32'(a_hit), 32'(ea.h));
                chk("a_cnt", 32'(a_cnt), 32'(ea.c));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_out", 32'(b_out), 32'(eb.o));
                chk("b_hit", 32'(b_hit), 32'(eb.h));
                chk("b_cnt", 32'(b_cnt), 32'(eb.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] run_cnt_tbl [5];
        logic [7:0] prev;
        run_cnt_tbl[0] = 8'h40; run_cnt_tbl[1] = 8'h80; run_cnt_tbl[2] = 8'hC0;
        run_cnt_tbl[3] = 8'hC0; run_cnt_tbl[4] = 8'hC0;

        // Reset state
        #2;
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_hit", 32'(a_hit), 32'h0);
        chk("rst_cnt", 32'(a_cnt), 32'h0);
        chk("rst_b_cnt", 32'(b_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic run on ch0, pol=0
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
        step_a(1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h00);
        step_a(1, 0, 0, 4'b0001, 4'b0001, 4'b0001, 8'h01);
        step_a(1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 8'h01);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01);

        // pol=1, two runs of zeros on ch2; other channels held at 1
        step_a(1, 1, 0, 4'b1011, 4'b0000, 4'b0000, 8'h01);
        step_a(1, 1, 0, 4'b1011, 4'b0100, 4'b0100, 8'h11);
        step_a(1, 1, 0, 4'b1111, 4'b0000, 4'b0000, 8'h11);
        step_a(1, 1, 0, 4'b1011, 4'b0000, 4'b0000, 8'h11);
        step_a(1, 1, 0, 4'b1011, 4'b0100, 4'b0100, 8'h21);
        // pol flips: ch2's zero no longer matches, others start counting
        step_a(1, 0, 0, 4'b1011, 4'b0000, 4'b0000, 8'h21);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h21);

        // Enable gating
        step_a(1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h21);
        step_a(0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h21);
        step_a(0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h21);
        step_a(1, 0, 0, 4'b0001, 4'b0001, 4'b0001, 8'h22);
        step_a(0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 8'h22);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h22);

        // Clear with en=0
        step_a(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h00);

        // Saturation on ch3 (2-bit counter)
        for (int r = 0; r < 5; r++) begin
            prev = (r == 0) ? 8'h00 : run_cnt_tbl[r-1];
            step_a(1, 0, 0, 4'b1000, 4'b0000, 4'b0000, prev);
            step_a(1, 0, 0, 4'b1000, 4'b1000, 4'b1000, run_cnt_tbl[r]);
            step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, run_cnt_tbl[r]);
        end
        step_a(1, 0, 0, 4'b1000, 4'b0000, 4'b0000, 8'hC0);
        step_a(1, 0, 1, 4'b1000, 4'b1000, 4'b1000, 8'h00);
        step_a(1, 0, 0, 4'b1000, 4'b1000, 4'b0000, 8'h00);

        // Simultaneous hits on several channels
        step_a(1, 0, 0, 4'b1111, 4'b1000, 4'b0000, 8'h00);
        step_a(1, 0, 0, 4'b1111, 4'b1111, 4'b0111, 8'h15);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h15);

        // Asynchronous reset while in DETECT
        step_a(1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h15);
        step_a(1, 0, 0, 4'b0001, 4'b0001, 4'b0001, 8'h16);
        @(posedge clk);
        #3;
        rst = 1'b0;
        a_en = 1'b0;
        #1;
        chk("arst_out", 32'(a_out), 32'h0);
        chk("arst_hit", 32'(a_hit), 32'h0);
        chk("arst_cnt", 32'(a_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step_a(1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 8'h00);
        step_a(1, 0, 0, 4'b0001, 4'b0001, 4'b0001, 8'h01);
        step_a(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 8'h01);

        // MIN_RUN=3 instance: ch1 data 1,1,0,1,1,1
        @(negedge clk);
        a_en = 1'b0;
        step_b(2'b10, 2'b00, 2'b00, 16'h0000);
        step_b(2'b10, 2'b00, 2'b00, 16'h0000);
        step_b(2'b00, 2'b00, 2'b00, 16'h0000);
        step_b(2'b10, 2'b00, 2'b00, 16'h0000);
        step_b(2'b10, 2'b00, 2'b00, 16'h0000);
        step_b(2'b10, 2'b10, 2'b10, 16'h0100);
        step_b(2'b00, 2'b00, 2'b00, 16'h0100);

        repeat (3) @(posedge clk);
        #2;
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
